sdram_init_fsm: RTL and testbench

SDRAM_INIT_FSM -- requirements
Module: sdram_init_fsm

---
 rtl/sdram_pkg.sv | 38 +++
 rtl/sdram_init_fsm.sv | 126 ++++++++++++
 tb/tb_sdram_init_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, mode-register value, default timing.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    // Idle bus values: all banks selected, A10 high (precharge-all).
    localparam logic [1:0]  BA_IDLE   = 2'b11;
    localparam logic [12:0] ADDR_IDLE = 13'h1FFF;

    // Burst write, CAS latency 3, sequential, full-page burst.
    localparam logic [1:0]  MODE_REG_BA  = 2'b00;
    localparam logic [12:0] MODE_REG_VAL = 13'b000_0_00_011_0_111;

    // Default timing at 100 MHz, in clock cycles.
    localparam int T_POWER_DEF  = 20000;
    localparam int TRP_CLK_DEF  = 2;
    localparam int TRFC_CLK_DEF = 7;
    localparam int TMRD_CLK_DEF = 3;
    localparam int AR_NUM_DEF   = 8;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        TRP,
        AR,
        TRF,
        MRS,
        TMRD,
        END
    } init_state_t;

endpackage

// File: rtl/sdram_init_fsm.sv
// SDRAM power-up initialisation: wait, PRECHARGE-all, AR_NUM x AUTO REFRESH, MODE REGISTER SET.
// Latency: PRECHARGE T_POWER cycles after reset release; init_end T_POWER+71 cycles with defaults.
// Backpressure: none; free-running sequence, outputs registered, init_end sticky until reset.
// Ports: clk_100m, rst_n (async active-low) in; init_cmd[3:0], init_ba[1:0],
//        init_addr[12:0], init_end out.
module sdram_init_fsm
    import sdram_pkg::*;
#(
    parameter int T_POWER  = T_POWER_DEF,
    parameter int TRP_CLK  = TRP_CLK_DEF,
    parameter int TRFC_CLK = TRFC_CLK_DEF,
    parameter int TMRD_CLK = TMRD_CLK_DEF,
    parameter int AR_NUM   = AR_NUM_DEF
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    output logic [3:0]  init_cmd,
    output logic [1:0]  init_ba,
    output logic [12:0] init_addr,
    output logic        init_end
);

    // The power-up counter must reach T_POWER itself (not T_POWER-1), see IDLE below.
    localparam int PWR_W   = $clog2(T_POWER + 1);
    localparam int CYC_MAX = (TRFC_CLK > TRP_CLK) ?
                             ((TRFC_CLK > TMRD_CLK) ? TRFC_CLK : TMRD_CLK) :
                             ((TRP_CLK  > TMRD_CLK) ? TRP_CLK  : TMRD_CLK);
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int REF_W   = $clog2(AR_NUM + 1);

    init_state_t      state_q,   state_d;
    logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;

    logic [3:0]  cmd_d;
    logic [1:0]  ba_d;
    logic [12:0] addr_d;
    logic        end_d;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pwr_cnt_q <= '0;
            cyc_cnt_q <= '0;
            ref_cnt_q <= '0;
            init_cmd  <= CMD_NOP;
            init_ba   <= BA_IDLE;
            init_addr <= ADDR_IDLE;
            init_end  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            init_cmd  <= cmd_d;
            init_ba   <= ba_d;
            init_addr <= addr_d;
            init_end  <= end_d;
        end
    end

    // Next state. Wait states exit when the counter shows N-1 so that exactly
    // N NOP cycles appear on the registered outputs.
    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q;
        cyc_cnt_d = '0;
        ref_cnt_d = ref_cnt_q;
        unique case (state_q)
            IDLE: begin
                // Before edge n the counter holds n, so leaving at T_POWER puts
                // PRECHARGE on the bus in cycle n = T_POWER.
                if (pwr_cnt_q == PWR_W'(T_POWER)) state_d = PRE;
                else                              pwr_cnt_d = pwr_cnt_q + 1'b1;
            end
            PRE: state_d = TRP;
            TRP: begin
                if (cyc_cnt_q == CYC_W'(TRP_CLK - 1)) state_d = AR;
                else                                   cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
            AR: begin
                ref_cnt_d = ref_cnt_q + 1'b1;
                state_d   = TRF;
            end
            TRF: begin
                if (cyc_cnt_q == CYC_W'(TRFC_CLK - 1))
                    state_d = (ref_cnt_q < REF_W'(AR_NUM)) ? AR : MRS;
                else
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
            MRS: state_d = TMRD;
            TMRD: begin
                if (cyc_cnt_q == CYC_W'(TMRD_CLK - 1)) state_d = END;
                else                                    cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
            END:     state_d = END;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            pwr_cnt_d = '0;
            cyc_cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so the registered bus lines up
    // with the state register.
    always_comb begin
        cmd_d  = CMD_NOP;
        ba_d   = BA_IDLE;
        addr_d = ADDR_IDLE;
        end_d  = 1'b0;
        unique case (state_d)
            PRE: cmd_d = CMD_PRECHARGE;
            AR:  cmd_d = CMD_AUTO_REF;
            MRS: begin
                cmd_d  = CMD_MRS;
                ba_d   = MODE_REG_BA;
                addr_d = MODE_REG_VAL;
            end
            END:     end_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_init_fsm.sv
// Directed bench for sdram_init_fsm: default timing, short power-up, mid-sequence reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_init_fsm;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRC = 4'b0010;
    localparam logic [3:0] ARF = 4'b0001;
    localparam logic [3:0] MRS_C = 4'b0000;

    logic        clk_100m = 1'b0;
    logic        rst_n_a  = 1'b0;
    logic        rst_n_b  = 1'b0;
    logic [3:0]  cmd_a, cmd_b;
    logic [1:0]  ba_a, ba_b;
    logic [12:0] addr_a, addr_b;
    logic        end_a, end_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_100m = ~clk_100m;

    sdram_init_fsm dut_a (
        .clk_100m  (clk_100m),
        .rst_n     (rst_n_a),
        .init_cmd  (cmd_a),
        .init_ba   (ba_a),
        .init_addr (addr_a),
        .init_end  (end_a)
    );

    sdram_init_fsm #(.T_POWER(10)) dut_b (
        .clk_100m  (clk_100m),
        .rst_n     (rst_n_b),
        .init_cmd  (cmd_b),
        .init_ba   (ba_b),
        .init_addr (addr_b),
        .init_end  (end_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected command in cycle n, from the documented schedule:
    // PRE at tp, AUTO_REF at tp+3+8k (k=0..7), MRS at tp+67, NOP otherwise.
    function automatic logic [3:0] exp_cmd(input int n, input int tp);
        int d;
        d = n - tp - 3;
        if (n == tp)                              return PRC;
        if (d >= 0 && d < 64 && (d % 8) == 0)     return ARF;
        if (n == tp + 67)                         return MRS_C;
        return NOP;
    endfunction

    task automatic sample(input bit use_b, output logic [3:0] c, output logic [1:0] ba,
                          output logic [12:0] ad, output logic e);
        c  = use_b ? cmd_b  : cmd_a;
        ba = use_b ? ba_b   : ba_a;
        ad = use_b ? addr_b : addr_a;
        e  = use_b ? end_b  : end_a;
    endtask

    // Walks cycles n = 0..ncyc-1 after reset release (caller releases reset on
    // a negedge, so the next posedge is n = 0).
    task automatic run_trace(input bit use_b, input int tp, input int ncyc, input string tag);
        logic [3:0]  c, ec, prev_c;
        logic [1:0]  ba;
        logic [12:0] ad;
        logic        e;
        int bad_cmd = 0, bad_bus = 0, bad_end = 0, n_ar = 0, gap_viol = 0;
        int first_end = -1, last_nn = -1000, mrs_n = -1;
        logic [3:0] last_kind = NOP;
        prev_c = NOP;
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk_100m);
            #1;
            sample(use_b, c, ba, ad, e);
            ec = exp_cmd(n, tp);
            if (c !== ec) bad_cmd++;
            if (ec == MRS_C) begin
                if (ba !== 2'b00 || ad !== 13'h0037) bad_bus++;
            end else if (ec != ARF) begin
                if (ba !== 2'b11 || ad !== 13'h1FFF) bad_bus++;
            end
            if (e !== (n >= tp + 71)) bad_end++;
            if (e === 1'b1 && first_end < 0) first_end = n;
            if (c === ARF) n_ar++;
            // One-cycle commands and minimum gaps (tRP=2, tRFC=7, tMRD=3 NOPs).
            if (c !== NOP) begin
                if (prev_c !== NOP) gap_viol++;
                if (c === ARF && last_kind == PRC && n - last_nn < 3) gap_viol++;
                if (c === ARF && last_kind == ARF && n - last_nn < 8) gap_viol++;
                if (c === MRS_C && n - last_nn < 8) gap_viol++;
                if (c === MRS_C) mrs_n = n;
                last_kind = c;
                last_nn   = n;
            end
            prev_c = c;
            if (n == 0)       check({tag, "_cmd_n0"}, 32'(c), 32'(NOP));
            if (n == tp - 1)  check({tag, "_cmd_pre_minus1"}, 32'(c), 32'(NOP));
            if (n == tp) begin
                check({tag, "_pre_cmd"}, 32'(c), 32'(PRC));
                check({tag, "_pre_addr"}, 32'(ad), 32'h1FFF);
                check({tag, "_pre_ba"}, 32'(ba), 32'h3);
            end
            if (n == tp + 3)  check({tag, "_ar0_cmd"}, 32'(c), 32'(ARF));
            if (n == tp + 67) begin
                check({tag, "_mrs_cmd"}, 32'(c), 32'(MRS_C));
                check({tag, "_mrs_addr"}, 32'(ad), 32'h0037);
                check({tag, "_mrs_ba"}, 32'(ba), 32'h0);
            end
            if (n == tp + 70) check({tag, "_end_before"}, 32'(e), 32'h0);
            if (n == tp + 71) check({tag, "_end_rise"}, 32'(e), 32'h1);
            if (n == ncyc - 1) begin
                check({tag, "_end_held"}, 32'(e), 32'h1);
                check({tag, "_end_nop"}, 32'(c), 32'(NOP));
            end
        end
        check({tag, "_cmd_trace_bad"}, bad_cmd, 0);
        check({tag, "_bus_trace_bad"}, bad_bus, 0);
        check({tag, "_end_trace_bad"}, bad_end, 0);
        check({tag, "_ar_count"}, n_ar, 8);
        check({tag, "_gap_viol"}, gap_viol, 0);
        check({tag, "_first_end"}, first_end, tp + 71);
        check({tag, "_mrs_to_end"}, first_end - mrs_n, 4);
    endtask

    task automatic check_reset_vals(input bit use_b, input string tag);
        logic [3:0]  c;
        logic [1:0]  ba;
        logic [12:0] ad;
        logic        e;
        sample(use_b, c, ba, ad, e);
        check({tag, "_cmd"}, 32'(c), 32'(NOP));
        check({tag, "_ba"}, 32'(ba), 32'h3);
        check({tag, "_addr"}, 32'(ad), 32'h1FFF);
        check({tag, "_end"}, 32'(e), 32'h0);
    endtask

    initial begin
        logic [3:0]  c;
        logic [1:0]  ba;
        logic [12:0] ad;
        logic        e;

        repeat (3) @(posedge clk_100m);
        #1;
        check_reset_vals(1'b0, "rst_a");
        check_reset_vals(1'b1, "rst_b");

        // Default parameters: full sequence plus 1000 cycles of held init_end.
        @(negedge clk_100m);
        rst_n_a = 1'b1;
        run_trace(1'b0, 20000, 21072, "dflt");

        // Short power-up wait.
        @(negedge clk_100m);
        rst_n_b = 1'b1;
        run_trace(1'b1, 10, 200, "short");

        // Restart, then reset during the 5th refresh (AUTO_REF at n=45).
        @(negedge clk_100m);
        rst_n_b = 1'b0;
        @(negedge clk_100m);
        rst_n_b = 1'b1;
        for (int n = 0; n <= 47; n++) begin
            @(posedge clk_100m);
            #1;
            if (n == 45) begin
                sample(1'b1, c, ba, ad, e);
                check("mid_ar5_cmd", 32'(c), 32'(ARF));
            end
        end
        rst_n_b = 1'b0;
        #1;
        check_reset_vals(1'b1, "mid_rst");
        @(posedge clk_100m);
        #1;
        check_reset_vals(1'b1, "mid_rst_hold");
        @(negedge clk_100m);
        rst_n_b = 1'b1;
        run_trace(1'b1, 10, 120, "restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
